inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 140 ++++++++++++++
 tb/tb_inst_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction memory, fills the IF/ID
// slot, and absorbs decode stalls and branch redirects via a one-word skid.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_SKID,
    S_DRAIN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;
  logic [31:0] r_skid_word, w_skid_word_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic        r_skid_full, w_skid_full_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;

  logic        w_free;
  logic        w_take;
  logic [31:0] w_tgt;

  assign imem_req    = (r_state == S_BUSY) || (r_state == S_DRAIN);
  assign imem_addr   = r_fetch_pc;
  assign instruction = r_instr;
  assign pc_out      = r_pc;
  assign inst_valid  = r_valid;

  assign w_free = !r_valid || !stall;
  assign w_take = r_valid && !stall;
  assign w_tgt  = branch_target & ~32'h0000_0003;

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_redir_pc_nxt  = r_redir_pc;
    w_skid_word_nxt = r_skid_word;
    w_skid_pc_nxt   = r_skid_pc;
    w_skid_full_nxt = r_skid_full;
    w_instr_nxt     = r_instr;
    w_pc_nxt        = r_pc;
    w_valid_nxt     = r_valid;
    if (branch_taken) begin
      w_valid_nxt     = 1'b0;
      w_skid_full_nxt = 1'b0;
      if (r_state == S_BUSY && !imem_ack) begin
        w_redir_pc_nxt = w_tgt;
        w_state_nxt    = S_DRAIN;
      end else if (r_state == S_DRAIN && !imem_ack) begin
        w_redir_pc_nxt = w_tgt;
      end else begin
        // Outstanding request (if any) completes now; its word is dropped.
        w_redir_pc_nxt = w_tgt;
        w_fetch_pc_nxt = w_tgt;
        w_state_nxt    = S_BUSY;
      end
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_BUSY;
        S_BUSY: begin
          if (imem_ack) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            if (w_free) begin
              w_instr_nxt = imem_rdata;
              w_pc_nxt    = r_fetch_pc;
              w_valid_nxt = 1'b1;
            end else begin
              w_skid_word_nxt = imem_rdata;
              w_skid_pc_nxt   = r_fetch_pc;
              w_skid_full_nxt = 1'b1;
              w_state_nxt     = S_SKID;
            end
          end else if (w_take) begin
            w_valid_nxt = 1'b0;
          end
        end
        S_SKID: begin
          if (!stall) begin
            w_instr_nxt     = r_skid_word;
            w_pc_nxt        = r_skid_pc;
            w_valid_nxt     = 1'b1;
            w_skid_full_nxt = 1'b0;
            w_state_nxt     = S_BUSY;
          end
        end
        S_DRAIN: begin
          if (w_take) w_valid_nxt = 1'b0;
          if (imem_ack) begin
            w_fetch_pc_nxt = r_redir_pc;
            w_state_nxt    = S_BUSY;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_redir_pc  <= RESET_PC;
      r_skid_word <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_full <= 1'b0;
      r_instr     <= 32'd0;
      r_pc        <= 32'd0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_redir_pc  <= w_redir_pc_nxt;
      r_skid_word <= w_skid_word_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_full <= w_skid_full_nxt;
      r_instr     <= w_instr_nxt;
      r_pc        <= w_pc_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic
// checked against a transaction-level fetch model.
module tb_inst_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
  logic        imem_req2, inst_valid2;
  logic [31:0] imem_addr2, imem_rdata2, instruction2, pc_out2;

  assign imem_rdata  = imem_addr ^ K;
  assign imem_rdata2 = imem_addr2 ^ K;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instruction(instruction), .pc_out(pc_out),
    .inst_valid(inst_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata2),
    .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instruction(instruction2), .pc_out(pc_out2),
    .inst_valid(inst_valid2)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: an outstanding-request flag, a discard flag,
  // a word queue for the held-back fetch, and the IF/ID slot.
  logic        m_req, m_discard, m_valid;
  logic [31:0] m_addr, m_redir, m_word, m_pc;
  logic [63:0] m_buf[$];

  task automatic model_step();
    logic ack, take, free;
    logic [31:0] tgt;
    logic [63:0] e;
    if (rst) begin
      m_req = 0; m_discard = 0; m_valid = 0;
      m_addr = 32'd0; m_redir = 32'd0;
      m_word = 32'd0; m_pc = 32'd0;
      m_buf.delete();
      return;
    end
    ack  = m_req && imem_ack;
    take = m_valid && !stall;
    free = !m_valid || !stall;
    tgt  = {branch_target[31:2], 2'b00};
    if (branch_taken) begin
      m_valid = 0;
      m_buf.delete();
      if (!m_req || ack) begin
        m_addr = tgt; m_req = 1; m_discard = 0;
      end else begin
        m_redir = tgt; m_discard = 1;
      end
    end else if (!m_req) begin
      if (m_buf.size() == 0) m_req = 1;
      else if (!stall) begin
        e = m_buf.pop_front();
        m_word = e[63:32]; m_pc = e[31:0];
        m_valid = 1; m_req = 1;
      end
    end else begin
      if (take) m_valid = 0;
      if (ack) begin
        if (m_discard) begin
          m_addr = m_redir; m_discard = 0;
        end else if (free) begin
          m_word = m_addr ^ K; m_pc = m_addr;
          m_valid = 1; m_addr = m_addr + 32'd4;
        end else begin
          m_buf.push_back({m_addr ^ K, m_addr});
          m_addr = m_addr + 32'd4; m_req = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic a, input logic s,
                      input logic b, input logic [31:0] t);
    rst = r; imem_ack = a; stall = s;
    branch_taken = b; branch_target = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req got %b want 0", imem_req);
    end
    n_checks++;
    if (inst_valid !== 1'b0 || instruction !== 32'd0 || pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_slot got v=%b i=%h pc=%h want 0", inst_valid, instruction, pc_out);
    end
    n_checks++;
    if (imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_rise got req=%b v=%b want 1,0", imem_req, inst_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0);
      exp = 32'(i * 4);
      n_checks++;
      if (inst_valid !== 1'b1 || pc_out !== exp || instruction !== (exp ^ K)) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b pc=%h i=%h want pc=%h", i, inst_valid, pc_out, instruction, exp);
      end
    end
  endtask

  task automatic test_stall_skid();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 0, 0);
      n_checks++;
      if (inst_valid !== 1'b1 || pc_out !== 32'd8 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%b pc=%h req=%b want 1,8,0", i, inst_valid, pc_out, imem_req);
      end
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'd12 || instruction !== (32'd12 ^ K) || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_out got v=%b pc=%h req=%b want pc=0c req=1", inst_valid, pc_out, imem_req);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (pc_out !== 32'd16 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL after_skid got pc=%h want 10", pc_out);
    end
  endtask

  task automatic test_branch_drain();
    tick(0, 0, 0, 1, 32'h0000_0103);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd20) begin
      n_fail++;
      $display("FAIL drain_enter got v=%b req=%b a=%h want 0,1,14", inst_valid, imem_req, imem_addr);
    end
    tick(0, 0, 0, 0, 0);
    n_checks++;
    if (imem_addr !== 32'd20 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold got a=%h v=%b want 14,0", imem_addr, inst_valid);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_drop got v=%b a=%h req=%b want 0,100,1", inst_valid, imem_addr, imem_req);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h100 || instruction !== (32'h100 ^ K)) begin
      n_fail++; $display("FAIL drain_target got v=%b pc=%h want 1,100", inst_valid, pc_out);
    end
  endtask

  task automatic test_branch_skid();
    tick(0, 1, 1, 0, 0);
    n_checks++;
    if (imem_req !== 1'b0 || pc_out !== 32'h100) begin
      n_fail++; $display("FAIL skid_fill got req=%b pc=%h want 0,100", imem_req, pc_out);
    end
    tick(0, 0, 1, 1, 32'h0000_0200);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL skid_branch got v=%b req=%b a=%h want 0,1,200", inst_valid, imem_req, imem_addr);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h200) begin
      n_fail++; $display("FAIL skid_discard got v=%b pc=%h want 1,200", inst_valid, pc_out);
    end
  endtask

  task automatic test_mid_reset();
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    n_checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst got req=%b v=%b want 0,0", imem_req, inst_valid);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL late_ack got v=%b req=%b a=%h want 0,1,0", inst_valid, imem_req, imem_addr);
    end
    tick(0, 1, 0, 0, 0);
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'd0) begin
      n_fail++; $display("FAIL restart got v=%b pc=%h want 1,0", inst_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    exp = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0);
      n_checks++;
      if (inst_valid2 !== 1'b1 || pc_out2 !== exp || instruction2 !== (exp ^ K)) begin
        n_fail++; $display("FAIL wrap%0d got pc=%h want %h", i, pc_out2, exp);
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_random();
    logic r, a, s, b;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(63) == 0);
      a = ($urandom_range(9) < 6);
      s = ($urandom_range(9) < 3);
      b = ($urandom_range(9) == 0);
      tick(r, a, s, b, $urandom);
      n_checks++;
      if (imem_req !== m_req || imem_addr !== m_addr || inst_valid !== m_valid ||
          pc_out !== m_pc || instruction !== m_word) begin
        n_fail++;
        $display("FAIL rand%0d got req=%b a=%h v=%b pc=%h i=%h want %b %h %b %h %h",
                 i, imem_req, imem_addr, inst_valid, pc_out, instruction,
                 m_req, m_addr, m_valid, m_pc, m_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_branch_drain();
    test_branch_skid();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
